// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl: tic-tac-toe board owner with move legality checks, turn alternation and win/draw detection
module ttt_game_ctrl #(
    parameter int FIRST_PLAYER = 1,
    parameter bit ALT_START    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       place,
    input  logic       new_game,
    input  logic [1:0] row,
    input  logic [1:0] col,
    output logic [1:0] grid [2:0][2:0],
    output logic [1:0] turn,
    output logic [1:0] winner,
    output logic       game_over,
    output logic       illegal,
    output logic [3:0] move_count
);
    typedef enum logic [1:0] {PLAY, CHECK, OVER} state_t;
    state_t state;
    logic place_q, new_game_q, place_rise, new_game_rise, occupied, win;
    logic [1:0] start, next_start;
    logic [8:0] m;
    assign place_rise    = place & ~place_q;
    assign new_game_rise = new_game & ~new_game_q;
    assign next_start    = ALT_START ? 2'd3 - start : start;
    always_comb begin
        occupied = 1'b1; // out-of-range coordinates never match a cell, so they read as unavailable
        m = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                if (row == 2'(r) && col == 2'(c)) occupied = grid[r][c] != 2'd0;
                m[3*r+c] = grid[r][c] == turn;
            end
        win = (&m[2:0]) | (&m[5:3]) | (&m[8:6]) |
              (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
              (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) grid[r][c] <= 2'd0;
            state      <= PLAY;
            turn       <= 2'(FIRST_PLAYER);
            start      <= 2'(FIRST_PLAYER);
            winner     <= 2'd0;
            game_over  <= 1'b0;
            illegal    <= 1'b0;
            move_count <= 4'd0;
            place_q    <= 1'b0;
            new_game_q <= 1'b0;
        end else begin
            place_q    <= place;
            new_game_q <= new_game;
            illegal    <= 1'b0;
            if (new_game_rise) begin
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++) grid[r][c] <= 2'd0;
                state      <= PLAY;
                start      <= next_start;
                turn       <= next_start;
                winner     <= 2'd0;
                game_over  <= 1'b0;
                move_count <= 4'd0;
            end else begin
                case (state)
                    PLAY: if (place_rise) begin
                        if (!occupied) begin
                            for (int r = 0; r < 3; r++)
                                for (int c = 0; c < 3; c++)
                                    if (row == 2'(r) && col == 2'(c)) grid[r][c] <= turn;
                            move_count <= move_count + 4'd1;
                            state      <= CHECK;
                        end else
                            illegal <= 1'b1;
                    end
                    CHECK: begin
                        if (win || move_count == 4'd9) begin
                            winner    <= win ? turn : 2'd0;
                            game_over <= 1'b1;
                            state     <= OVER;
                        end else begin
                            turn  <= 2'd3 - turn;
                            state <= PLAY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
